// File: rtl/uart_tx_param.sv
// uart_tx_param: FIFO-buffered UART transmitter.
// The frame format is set by parameters: data bits, optional odd/even parity,
// and one or two stop bits. Tx, Tx_busy and Tx_done come straight from flops.
//
// Handshake: a word is written on every rising edge where Tx_en && Tx_ready.
// Tx_ready is low only while the holding FIFO is full. A Tx_en that arrives
// while the FIFO is full is dropped, and no error is flagged.
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk_100MHz,
  input  logic                          rst,
  input  logic                          Tx_en,
  input  logic [DATA_BITS-1:0]          Din,
  output logic                          Tx_ready,
  output logic                          Tx,
  output logic                          Tx_busy,
  output logic                          Tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [2:0]                    fsm_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [AW:0]   FULL     = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [BW-1:0] BIT_MAX  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic          STOP_MAX = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  // Holding FIFO
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;

  assign Tx_ready = (fifo_level != FULL);
  assign push     = Tx_en && Tx_ready;
  assign head     = mem[rd_ptr];

  // FIFO storage is not reset; only the pointers and the level define its contents
  always_ff @(posedge clk_100MHz) begin
    if (push) mem[wr_ptr] <= Din;
  end

  // FIFO pointers and level; a push and a pop on the same edge cancel in the level
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_ONE;
        2'b01:   fifo_level <= fifo_level - LVL_ONE;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Frame engine state
  state_t               state, state_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic [BW-1:0]        bit_idx, bit_d;
  logic                 stop_idx, stop_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic                 par_bit, par_d;
  logic                 tx_d, busy_d, done_d;
  logic                 cnt_last, load;

  assign cnt_last  = (cnt == CNT_MAX);
  assign fsm_state = state;

  // Next state: outputs are computed for the cycle that follows, then registered
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    bit_d   = bit_idx;
    stop_d  = stop_idx;
    shreg_d = shreg;
    par_d   = par_bit;
    tx_d    = Tx;
    load    = 1'b0;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        tx_d = 1'b1;
        if (fifo_level != '0) load = 1'b1;
      end
      START: begin
        if (cnt_last) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shreg[0];
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (bit_idx == BIT_MAX) begin
            stop_d = 1'b0;
            if (PARITY != 0) begin
              state_d = PAR;
              tx_d    = par_bit;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_idx + BIT_ONE;
            shreg_d = shreg >> 1;
            tx_d    = shreg[1];
          end
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      PAR: begin
        if (cnt_last) begin
          state_d = STOP;
          cnt_d   = '0;
          stop_d  = 1'b0;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (cnt_last) begin
          cnt_d = '0;
          if (stop_idx == STOP_MAX) begin
            // Chain straight into the next frame when a word is waiting
            if (fifo_level != '0) load = 1'b1;
            else                  state_d = IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
    if (load) begin
      pop     = 1'b1;
      state_d = START;
      cnt_d   = '0;
      shreg_d = head;
      par_d   = (PARITY == 2) ? ^head : ~^head;
      tx_d    = 1'b0;
    end
    busy_d = (state_d != IDLE);
    // Registered so that it is high exactly in the final cycle of STOP
    done_d = (state_d == STOP) && (cnt_d == CNT_MAX) && (stop_d == STOP_MAX);
  end

  // State and output registers; reset aborts any frame and forces the line idle
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      Tx       <= 1'b1;
      Tx_busy  <= 1'b0;
      Tx_done  <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      bit_idx  <= bit_d;
      stop_idx <= stop_d;
      shreg    <= shreg_d;
      par_bit  <= par_d;
      Tx       <= tx_d;
      Tx_busy  <= busy_d;
      Tx_done  <= done_d;
    end
  end

endmodule
